// File: rtl/seg7_pattern_decoder.sv
// Recovers a 3-bit index from an active-low 7-segment pattern. A pattern must be
// stable for a qualification window before it is decoded and presented on a valid/ready output.
module seg7_pattern_decoder #(
   parameter int STABLE_CYCLES = 4,
   parameter int ERR_CNT_W     = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [6:0]           seg_in,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [2:0]           out_idx,
   output logic [7:0]           out_onehot,
   output logic                 err,
   output logic [ERR_CNT_W-1:0] err_count,
   output logic                 overrun
);

   localparam logic [7:0]           STAB_MAX = 8'(STABLE_CYCLES - 1);
   localparam logic [6:0]           BLANK    = 7'h7F;
   localparam logic [ERR_CNT_W-1:0] ERR_ONE  = ERR_CNT_W'(1);

   typedef enum logic {
      SETTLE,
      LOCKED
   } state_t;

   state_t     state;
   state_t     state_nxt;
   logic [6:0] seg_q;
   logic [6:0] last_pat;
   logic [7:0] stab_cnt;
   logic       seg_same;
   logic       qualify;
   logic       code_ok;
   logic       is_blank;
   logic [2:0] code_idx;
   logic       accept;

   assign seg_same = (seg_in == seg_q);
   assign is_blank = (seg_q == BLANK);
   assign accept   = out_valid && out_ready;

   // LOCKED means seg_q already equals last_pat, so nothing can qualify until the input moves.
   always_comb begin
      state_nxt = state;
      qualify   = 1'b0;
      case (state)
         SETTLE: begin
            if ((stab_cnt == STAB_MAX) && seg_same && (seg_q != last_pat)) begin
               qualify   = 1'b1;
               state_nxt = LOCKED;
            end
         end
         LOCKED: begin
            if (!seg_same) begin
               state_nxt = SETTLE;
            end
         end
         default: state_nxt = SETTLE;
      endcase
   end

   always_comb begin
      code_ok  = 1'b1;
      code_idx = 3'd0;
      case (seg_q)
         7'b0000001: code_idx = 3'd0;
         7'b1001111: code_idx = 3'd1;
         7'b0010010: code_idx = 3'd2;
         7'b0000110: code_idx = 3'd3;
         7'b1001100: code_idx = 3'd4;
         7'b0100100: code_idx = 3'd5;
         7'b0100000: code_idx = 3'd6;
         7'b0001111: code_idx = 3'd7;
         default:    code_ok  = 1'b0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= SETTLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         seg_q    <= BLANK;
         last_pat <= BLANK;
         stab_cnt <= 8'd0;
      end else begin
         seg_q <= seg_in;
         if (!seg_same) begin
            stab_cnt <= 8'd0;
         end else if (stab_cnt != STAB_MAX) begin
            stab_cnt <= stab_cnt + 8'd1;
         end
         if (qualify) begin
            last_pat <= seg_q;
         end
      end
   end

   // A load on the same edge as an accept overrides the clear, keeping out_valid high.
   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid  <= 1'b0;
         out_idx    <= 3'd0;
         out_onehot <= 8'd0;
         err        <= 1'b0;
         err_count  <= '0;
         overrun    <= 1'b0;
      end else begin
         err <= 1'b0;
         if (accept) begin
            out_valid  <= 1'b0;
            out_onehot <= 8'd0;
         end
         if (qualify) begin
            if (code_ok) begin
               if (!out_valid || out_ready) begin
                  out_valid  <= 1'b1;
                  out_idx    <= code_idx;
                  out_onehot <= 8'd1 << code_idx;
               end else begin
                  overrun <= 1'b1;
               end
            end else if (!is_blank) begin
               err <= 1'b1;
               if (err_count != '1) begin
                  err_count <= err_count + ERR_ONE;
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_seg7_pattern_decoder.sv
// Randomized and directed bench for seg7_pattern_decoder, checked every cycle
// against a queue-based model of the qualification and handshake rules.
module tb_seg7_pattern_decoder;

   localparam int S       = 4;
   localparam int EW      = 8;
   localparam int ERR_MAX = (1 << EW) - 1;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic [6:0]    seg_in = 7'h7F;
   logic          out_ready = 1'b0;
   logic          out_valid;
   logic [2:0]    out_idx;
   logic [7:0]    out_onehot;
   logic          err;
   logic [EW-1:0] err_count;
   logic          overrun;

   int n_checks = 0;
   int n_fail   = 0;
   bit chk_en   = 1'b0;

   logic [6:0] codes [8] = '{7'h01, 7'h4F, 7'h12, 7'h06, 7'h4C, 7'h24, 7'h20, 7'h0F};

   logic [6:0] hist [$];
   logic [6:0] m_last = 7'h7F;
   bit         m_valid = 1'b0;
   logic [2:0] m_idx = 3'd0;
   logic [7:0] m_onehot = 8'd0;
   bit         m_err = 1'b0;
   int         m_err_count = 0;
   bit         m_overrun = 1'b0;

   seg7_pattern_decoder #(
      .STABLE_CYCLES(S),
      .ERR_CNT_W    (EW)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .seg_in    (seg_in),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_idx   (out_idx),
      .out_onehot(out_onehot),
      .err       (err),
      .err_count (err_count),
      .overrun   (overrun)
   );

   always #5 clk = ~clk;

   function automatic int code_index(input logic [6:0] p);
      for (int i = 0; i < 8; i++) begin
         if (codes[i] == p) return i;
      end
      return -1;
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Drives one cycle of inputs at a falling edge and returns at the next falling edge.
   task automatic applyStimulus(input logic [6:0] seg, input logic ready, input logic r);
      seg_in    = seg;
      out_ready = ready;
      rst       = r;
      @(negedge clk);
   endtask

   // A pattern qualifies once the last S+1 samples agree and it differs from the last accepted one.
   task automatic model_step();
      bit all_same;
      int ix;
      if (rst) begin
         hist.delete();
         hist.push_back(7'h7F);
         m_last = 7'h7F; m_valid = 1'b0; m_idx = 3'd0; m_onehot = 8'd0;
         m_err = 1'b0; m_err_count = 0; m_overrun = 1'b0;
         return;
      end
      hist.push_back(seg_in);
      if (hist.size() > S + 1) void'(hist.pop_front());
      m_err = 1'b0;
      if (m_valid && out_ready) begin
         m_valid  = 1'b0;
         m_onehot = 8'd0;
      end
      all_same = (hist.size() == S + 1);
      foreach (hist[i]) if (hist[i] != seg_in) all_same = 1'b0;
      if (all_same && seg_in != m_last) begin
         m_last = seg_in;
         ix = code_index(seg_in);
         if (ix >= 0) begin
            if (!m_valid) begin
               m_valid  = 1'b1;
               m_idx    = 3'(ix);
               m_onehot = 8'd1 << ix;
            end else begin
               m_overrun = 1'b1;
            end
         end else if (seg_in != 7'h7F) begin
            m_err = 1'b1;
            if (m_err_count < ERR_MAX) m_err_count++;
         end
      end
   endtask

   always @(posedge clk) model_step();

   always @(negedge clk) begin
      if (chk_en) begin
         checkOutput("out_valid", out_valid, m_valid);
         checkOutput("out_idx", out_idx, m_idx);
         checkOutput("out_onehot", out_onehot, m_onehot);
         checkOutput("err", err, m_err);
         checkOutput("err_count", err_count, m_err_count);
         checkOutput("overrun", overrun, m_overrun);
      end
   end

   initial begin
      int first;
      int hits;
      int n1;
      int n2;
      int e;
      int v;
      int hold;
      int r;
      logic [2:0] got_idx;
      logic [7:0] got_oh;
      logic [6:0] pat;

      @(negedge clk);
      applyStimulus(7'h7F, 1'b0, 1'b1);
      applyStimulus(7'h7F, 1'b0, 1'b1);
      chk_en = 1'b1;
      checkOutput("reset_valid", out_valid, 0);
      checkOutput("reset_onehot", out_onehot, 0);
      checkOutput("reset_err_count", err_count, 0);

      first = -1; hits = 0; got_idx = 3'd0; got_oh = 8'd0;
      for (int k = 0; k < 10; k++) begin
         applyStimulus(7'h24, 1'b1, 1'b0);
         if (out_valid) begin
            hits++;
            if (first < 0) begin
               first = k; got_idx = out_idx; got_oh = out_onehot;
            end
         end
      end
      checkOutput("t1_latency", first, 4);
      checkOutput("t1_pulses", hits, 1);
      checkOutput("t1_idx", got_idx, 5);
      checkOutput("t1_onehot", got_oh, 8'h20);

      for (int k = 0; k < 20; k++) applyStimulus(7'h0F, 1'b0, 1'b0);
      checkOutput("t2_valid_held", out_valid, 1);
      checkOutput("t2_idx", out_idx, 7);
      checkOutput("t2_onehot", out_onehot, 8'h80);
      applyStimulus(7'h0F, 1'b1, 1'b0);
      checkOutput("t2_valid_drop", out_valid, 0);
      checkOutput("t2_onehot_clear", out_onehot, 0);
      checkOutput("t2_idx_kept", out_idx, 7);

      n1 = 0; n2 = 0;
      for (int k = 0; k < 12; k++) begin
         applyStimulus((k < 2) ? 7'h4F : 7'h12, 1'b1, 1'b0);
         if (out_valid && out_idx == 3'd1) n1++;
         if (out_valid && out_idx == 3'd2) n2++;
      end
      checkOutput("t3_glitch_idx1", n1, 0);
      checkOutput("t3_idx2_once", n2, 1);

      e = 0; v = 0;
      for (int k = 0; k < 8; k++) begin
         applyStimulus(7'h7E, 1'b1, 1'b0);
         if (err) e++;
         if (out_valid) v++;
      end
      checkOutput("t4_err_pulses", e, 1);
      checkOutput("t4_err_count1", err_count, 1);
      checkOutput("t4_no_valid", v, 0);
      for (int k = 0; k < 8; k++) applyStimulus(7'h7F, 1'b1, 1'b0);
      for (int k = 0; k < 8; k++) applyStimulus(7'h7E, 1'b1, 1'b0);
      checkOutput("t4_err_count2", err_count, 2);

      for (int k = 0; k < 8; k++) applyStimulus(7'h01, 1'b0, 1'b0);
      checkOutput("t5_idx0", out_idx, 0);
      for (int k = 0; k < 8; k++) applyStimulus(7'h7F, 1'b0, 1'b0);
      for (int k = 0; k < 8; k++) applyStimulus(7'h4C, 1'b0, 1'b0);
      checkOutput("t5_idx_kept", out_idx, 0);
      checkOutput("t5_overrun", overrun, 1);
      checkOutput("t5_valid_held", out_valid, 1);
      for (int k = 0; k < 8; k++) applyStimulus(7'h7F, 1'b0, 1'b0);
      for (int k = 0; k < 4; k++) applyStimulus(7'h24, 1'b0, 1'b0);
      applyStimulus(7'h24, 1'b1, 1'b0);
      checkOutput("t5_swap_valid", out_valid, 1);
      checkOutput("t5_swap_idx", out_idx, 5);
      checkOutput("t5_swap_onehot", out_onehot, 8'h20);

      applyStimulus(7'h12, 1'b0, 1'b0);
      applyStimulus(7'h12, 1'b0, 1'b0);
      applyStimulus(7'h12, 1'b0, 1'b1);
      checkOutput("t6_rst_valid", out_valid, 0);
      checkOutput("t6_rst_idx", out_idx, 0);
      checkOutput("t6_rst_overrun", overrun, 0);
      checkOutput("t6_rst_err_count", err_count, 0);
      first = -1; got_idx = 3'd0;
      for (int k = 0; k < 10; k++) begin
         applyStimulus(7'h12, 1'b0, 1'b0);
         if (out_valid && first < 0) begin
            first = k; got_idx = out_idx;
         end
      end
      checkOutput("t6_reemit_latency", first, 4);
      checkOutput("t6_reemit_idx", got_idx, 2);

      hold = 0; pat = 7'h7F;
      for (int c = 0; c < 3000; c++) begin
         if (hold == 0) begin
            r = $urandom_range(0, 9);
            if (r < 5) pat = codes[$urandom_range(0, 7)];
            else if (r < 7) pat = 7'h7F;
            else pat = 7'($urandom);
            hold = $urandom_range(1, 8);
         end
         hold--;
         applyStimulus(pat, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 299) == 0));
      end

      for (int c = 0; c < 260; c++) begin
         for (int k = 0; k < 6; k++) applyStimulus(7'h7F, 1'($urandom_range(0, 1)), 1'b0);
         for (int k = 0; k < 6; k++) applyStimulus(7'h7E, 1'($urandom_range(0, 1)), 1'b0);
      end
      checkOutput("sat_err_count", err_count, ERR_MAX);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/seg7_pattern_decoder.md
Name: seg7_pattern_decoder

Overview:
- Receive side of the 3-bit-index-to-7-segment path: takes an active-low 7-segment pattern (bit6 = a … bit0 = g) and recovers the index 0..7 it encodes.
- Output is a 3-bit index plus a one-hot byte, delivered on a valid/ready handshake.
- Each pattern must be stable for a qualification window before it is accepted, so glitches and mid-transition values are filtered.
- Invalid patterns are flagged and counted; blank is treated as idle.

Parameters:
- STABLE_CYCLES, 4, consecutive edges a pattern must persist after its first sample before acceptance (legal 1..255)
- ERR_CNT_W, 8, width of saturating error counter

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous reset, active-high
- seg_in  input  7  active-low segment pattern, bit6=a … bit0=g
- out_valid  output  1  decoded result held on out_idx/out_onehot
- out_ready  input  1  consumer accepts result when out_valid & out_ready at rising edge
- out_idx  output  3  decoded index
- out_onehot  output  8  1 << out_idx; all-zero when out_valid=0
- err  output  1  one-cycle pulse: an invalid pattern qualified
- err_count  output  ERR_CNT_W  saturating count of err pulses
- overrun  output  1  sticky: a valid decode was dropped because the output was still held

Behaviour:
- Reset (rst=1 at edge) values:
  - out_valid=0, out_idx=0, out_onehot=0, err=0, err_count=0, overrun=0
  - internal seg_q=7'h7F, last_pat=7'h7F, stab_cnt=0
  - Reset mid-operation discards any held result and any in-progress qualification.
- Sampling, every edge:
  - seg_q <= seg_in.
  - If seg_in==seg_q: stab_cnt <= min(stab_cnt+1, STABLE_CYCLES-1); else stab_cnt <= 0.
- Qualify condition (combinational): stab_cnt==STABLE_CYCLES-1 AND seg_in==seg_q AND seg_q!=last_pat.
- On a qualify edge: last_pat <= seg_q. Then classify the pattern:
  - Valid code table (active-low): 0=0000001, 1=1001111, 2=0010010, 3=0000110, 4=1001100, 5=0100100, 6=0100000, 7=0001111.
  - Valid code: load out_idx/out_onehot and set out_valid=1, if (out_valid==0) or (out_ready==1) that cycle. Otherwise drop the decode, set overrun=1, and leave the held data untouched.
  - Blank (1111111): update last_pat only. No output, no err.
  - Any other pattern: err=1 for exactly one cycle; err_count += 1, saturating at all-ones.
- Latency: a pattern applied before edge E0 and held produces out_valid or err visible after edge E0+STABLE_CYCLES.
- No re-emission: a pattern equal to last_pat never requalifies. Example: P, 1-cycle glitch Q, back to P → no output. Q never qualifies, and P equals last_pat. Re-sending the same digit requires an intervening different qualified pattern, e.g. blank.
- Handshake:
  - out_valid & out_ready at an edge with no qualify → out_valid <= 0, out_onehot <= 0. out_idx keeps its last value.
  - Held data is stable while out_valid=1 and out_ready=0.
  - Accept and new qualify on the same edge → new result loaded, out_valid stays 1, no overrun.
- The err pulse is independent of the handshake and never affects out_valid.
- overrun clears only on rst.
- Structure: two-state FSM.
  - SETTLE: stab_cnt counting.
  - LOCKED: seg_q==last_pat, waiting for change.
  - LOCKED→SETTLE when seg_in differs from seg_q.
  - SETTLE→LOCKED on the qualify edge.

Test Plan:
- rst, then seg_in=0100100 held 10 cycles, out_ready=1 → out_valid high exactly one cycle, appearing after edge E0+4; out_idx=5, out_onehot=8'h20. No further output while held.
- seg_in=0001111 held, out_ready=0 for 20 cycles → out_idx=7, out_onehot=8'h80, held stable. Raise out_ready → out_valid drops the next edge, out_onehot=0.
- seg_in=1001111 for 2 cycles, then 0010010 held (STABLE_CYCLES=4) → only idx=2 emitted; idx=1 never appears.
- seg_in=1111110 held → err pulses once, err_count=1, out_valid stays 0. Drive blank, then 1111110 again → err_count=2. With ERR_CNT_W=2, repeating 5 times → err_count=3.
- out_ready=0; qualify 0000001 (idx 0), then blank, then 1001100 → out_idx stays 0 and overrun=1. Qualify a new code in the same cycle out_ready=1 → new code loaded, out_valid stays 1.
- Assert rst while out_valid=1 and another pattern mid-qualification → all outputs 0 next edge. The same pattern re-held after reset is emitted (last_pat=blank).
